block_token_emitter: RTL and testbench
======================================

Name: block_token_emitter

Overview:
- Transmit-side counterpart of the begin/end block checker.
- Accepts tokens (BEGIN, END, SPACE, RAW) over a valid/ready handshake and serialises each into an 8-bit ASCII character stream, one character per clock, in the exact format the checker consumes.
- Tracks nesting depth locally and drives a `balanced` flag with the same semantics as the checker's `result`, so benches can compare the two cycle-for-cycle.

Parameters:
- DEPTH_W, 8: width of the nesting-depth counter; maximum depth is 2^DEPTH_W-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- tok_valid  input  1  token offered this cycle.
- tok_kind  input  2  00 BEGIN, 01 END, 10 SPACE, 11 RAW.
- tok_char  input  8  character emitted for RAW; ignored for other kinds.
- tok_ready  output  1  emitter can accept a token this cycle.
- out_char  output  8  ASCII character; 8'h00 when out_valid=0.
- out_valid  output  1  out_char is a stream character this cycle.
- depth  output  DEPTH_W  current accepted nesting depth.
- balanced  output  1  1 when depth==0 and no error has occurred.
- err  output  1  sticky: END at depth 0, or BEGIN at max depth.

Behaviour:
- Reset (reset==0 at a clock edge):
  - out_char=0, out_valid=0, depth=0, err=0, balanced=1.
  - State returns to IDLE and tok_ready=1.
  - A token mid-emission is abandoned; out_valid=0 from the next cycle.
- States: IDLE, EMIT. A 3-bit index selects the character within the current token.
- Token character sequences (lower case by default):
  - BEGIN: "begin " (6 chars: b,e,g,i,n,space).
  - END: "end " (4 chars).
  - SPACE: " " (1 char).
  - RAW: tok_char (1 char).
- Handshake:
  - Transfer occurs when tok_valid && tok_ready at a rising edge.
  - tok_ready=1 in IDLE, and in EMIT on the cycle the token's last character is on out_char. This allows back-to-back tokens with no gap.
  - tok_ready=0 otherwise.
  - tok_kind and tok_char are sampled only at transfer.
- Latency and timing:
  - The first character of an accepted token appears on out_char, with out_valid=1, in the cycle after transfer.
  - Remaining characters follow on consecutive cycles.
  - After the last character, with no new transfer, the block returns to IDLE, and out_valid=0 and out_char=0 the next cycle.
- Depth and err update in the cycle after transfer (registered):
  - BEGIN: if depth == max, err<=1 and depth holds; else depth+1.
  - END: if depth == 0, err<=1 and depth stays 0; else depth-1.
  - SPACE and RAW: no effect.
- balanced = (depth==0) && !err, combinational from registers. Once err=1, balanced stays 0 until reset, matching the checker's permanent-failure rule.
- Erroring tokens are still emitted in full, so the downstream checker observes the same violation.
- RAW characters are emitted verbatim. The emitter does not model the checker's word parsing for RAW; benches must keep RAW text keyword-free if using balanced as a reference.

Optional Feature:
- Macro: BLOCK_EMIT_CASE_MIX_EN.
- Defined:
  - A 1-bit case toggle (reset 0) flips after every emitted alphabetic character of a BEGIN or END token.
  - When the toggle is 1, that letter is emitted upper case (ASCII minus 8'h20).
  - Spaces and RAW characters are unaffected and do not flip the toggle.
  - Exercises the checker's case-insensitivity.
- Not defined: all keyword letters are lower case; no toggle register exists.

Test Plan:
- Reset, then one BEGIN -> out_char "b","e","g","i","n"," " on cycles t+1..t+6, out_valid=1 on those cycles, then 0; depth=1, balanced=0 from t+1.
- BEGIN then END back-to-back, tok_valid held high -> tok_ready=1 on the "space" cycle; stream "begin end " with no gap; depth returns to 0; balanced=1 after END transfer +1.
- END from reset -> err=1, depth=0, balanced=0; stream "end " still emitted; a later BEGIN+END leaves balanced=0.
- DEPTH_W=2: four BEGINs -> depth 1,2,3,3 with err=1 on the fourth.
- Reset driven low on the third character of "begin " -> next cycle out_valid=0, depth=0, err=0, balanced=1, tok_ready=1.
- With BLOCK_EMIT_CASE_MIX_EN: BEGIN, END -> "bEgIn " then "EnD " (toggle continues across tokens); RAW "x" emitted as "x".

Source files
------------

// File: rtl/block_token_emitter.sv
// Serialises BEGIN/END/SPACE/RAW tokens into the ASCII stream the block checker consumes.
// Optional BLOCK_EMIT_CASE_MIX_EN alternates keyword-letter case to exercise case-insensitivity.
module block_token_emitter #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tok_valid,
  input  logic [1:0]         tok_kind,
  input  logic [7:0]         tok_char,
  output logic               tok_ready,
  output logic [7:0]         out_char,
  output logic               out_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               err
);

  typedef enum logic {S_IDLE, S_EMIT} state_e;
  typedef enum logic [1:0] {
    K_BEGIN = 2'b00,
    K_END   = 2'b01,
    K_SPACE = 2'b10,
    K_RAW   = 2'b11
  } kind_e;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};
  localparam logic [7:0]         ASCII_SP  = 8'h20;

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  kind_e              kind_q, kind_d;
  logic [7:0]         raw_q, raw_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;

  logic [7:0] base_char;
  logic [7:0] emit_char;
  logic [2:0] last_idx;
  logic       is_last;
  logic       is_kw_letter;
  logic       accept;

  // Character ROM: keyword text is indexed by idx_q; the trailing space ends every keyword.
  always_comb begin
    base_char = ASCII_SP;
    last_idx  = 3'd0;
    unique case (kind_q)
      K_BEGIN: begin
        last_idx = 3'd5;
        unique case (idx_q)
          3'd0:    base_char = 8'h62;  // b
          3'd1:    base_char = 8'h65;  // e
          3'd2:    base_char = 8'h67;  // g
          3'd3:    base_char = 8'h69;  // i
          3'd4:    base_char = 8'h6e;  // n
          default: base_char = ASCII_SP;
        endcase
      end
      K_END: begin
        last_idx = 3'd3;
        unique case (idx_q)
          3'd0:    base_char = 8'h65;  // e
          3'd1:    base_char = 8'h6e;  // n
          3'd2:    base_char = 8'h64;  // d
          default: base_char = ASCII_SP;
        endcase
      end
      K_SPACE: base_char = ASCII_SP;
      K_RAW:   base_char = raw_q;
      default: base_char = ASCII_SP;
    endcase
  end

  assign is_last      = (idx_q == last_idx);
  assign is_kw_letter = ((kind_q == K_BEGIN) || (kind_q == K_END)) && !is_last;

`ifdef BLOCK_EMIT_CASE_MIX_EN
  logic case_q, case_d;

  assign case_d    = case_q ^ (out_valid && is_kw_letter);
  assign emit_char = (is_kw_letter && case_q) ? (base_char - 8'h20) : base_char;

  always_ff @(posedge clk) begin
    if (!reset) case_q <= 1'b0;
    else        case_q <= case_d;
  end
`else
  assign emit_char = base_char;
`endif

  assign out_valid = (state_q == S_EMIT);
  assign out_char  = out_valid ? emit_char : 8'h00;
  assign tok_ready = (state_q == S_IDLE) || is_last;
  assign accept    = tok_valid && tok_ready;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    kind_d  = kind_q;
    raw_d   = raw_q;
    depth_d = depth_q;
    err_d   = err_q;

    if (accept) begin
      state_d = S_EMIT;
      idx_d   = 3'd0;
      kind_d  = kind_e'(tok_kind);
      raw_d   = tok_char;
      unique case (kind_e'(tok_kind))
        K_BEGIN: if (depth_q == DEPTH_MAX) err_d = 1'b1;
                 else depth_d = depth_q + 1'b1;
        K_END:   if (depth_q == '0) err_d = 1'b1;
                 else depth_d = depth_q - 1'b1;
        default: ;
      endcase
    end else if (state_q == S_EMIT) begin
      if (is_last) state_d = S_IDLE;
      else         idx_d   = idx_q + 3'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // NOTE: token payload is only read while emitting, and loading it always precedes that, so it carries no reset.
  always_ff @(posedge clk) begin
    kind_q <= kind_d;
    raw_q  <= raw_d;
  end

  assign depth    = depth_q;
  assign err      = err_q;
  assign balanced = (depth_q == '0) && !err_q;

endmodule

// File: tb/tb_block_token_emitter.sv
// Bench for block_token_emitter: a queue-based stream model checked every cycle, plus directed literals.
// Builds with or without BLOCK_EMIT_CASE_MIX_EN; literal keyword strings follow the macro.
module tb_block_token_emitter;

  localparam logic [1:0] KB = 2'b00, KE = 2'b01, KS = 2'b10, KR = 2'b11;
  localparam int MAXD = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       tok_valid, tok_ready, out_valid, balanced, err;
  logic [1:0] tok_kind;
  logic [7:0] tok_char, out_char;
  logic [7:0] depth;

  logic       t2_valid, t2_ready, t2_ovalid, t2_bal, t2_err;
  logic [1:0] t2_kind;
  logic [7:0] t2_char, t2_ochar;
  logic [1:0] t2_depth;

  block_token_emitter #(.DEPTH_W(8)) dut (
    .clk(clk), .reset(reset), .tok_valid(tok_valid), .tok_kind(tok_kind),
    .tok_char(tok_char), .tok_ready(tok_ready), .out_char(out_char),
    .out_valid(out_valid), .depth(depth), .balanced(balanced), .err(err)
  );

  block_token_emitter #(.DEPTH_W(2)) dut2 (
    .clk(clk), .reset(reset), .tok_valid(t2_valid), .tok_kind(t2_kind),
    .tok_char(t2_char), .tok_ready(t2_ready), .out_char(t2_ochar),
    .out_valid(t2_ovalid), .depth(t2_depth), .balanced(t2_bal), .err(t2_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of characters still to appear on out_char, head = this cycle's character.
  logic [7:0] mq[$];
  int         m_depth;
  bit         m_err;
  bit         m_tog;
  bit         chk_en = 1'b0;

  function automatic void push_word(input string s, input bit keyword);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c;
      c = s.getc(i);
`ifdef BLOCK_EMIT_CASE_MIX_EN
      if (keyword && c != 8'h20) begin
        if (m_tog) c = c - 8'h20;
        m_tog = ~m_tog;
      end
`endif
      mq.push_back(c);
    end
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      m_depth = 0;
      m_err   = 1'b0;
      m_tog   = 1'b0;
    end else begin
      bit acc;
      acc = tok_valid && (mq.size() <= 1);
      if (mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        case (tok_kind)
          KB: begin
            push_word("begin ", 1'b1);
            if (m_depth == MAXD) m_err = 1'b1; else m_depth++;
          end
          KE: begin
            push_word("end ", 1'b1);
            if (m_depth == 0) m_err = 1'b1; else m_depth--;
          end
          KS: mq.push_back(8'h20);
          default: mq.push_back(tok_char);
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      ev = (mq.size() > 0);
      check("out_valid", out_valid, ev);
      check("out_char",  out_char,  ev ? mq[0] : 8'h00);
      check("tok_ready", tok_ready, mq.size() <= 1);
      check("depth",     depth,     m_depth);
      check("err",       err,       m_err);
      check("balanced",  balanced,  (m_depth == 0) && !m_err);
    end
  end

  logic [7:0] cap[$];
  always @(negedge clk) if (chk_en && out_valid) cap.push_back(out_char);

  task automatic cmp_str(input string name, input string exp);
    check({name, "_len"}, cap.size(), exp.len());
    for (int i = 0; i < exp.len(); i++)
      check($sformatf("%s[%0d]", name, i), (i < cap.size()) ? cap[i] : 8'h00, exp.getc(i));
  endtask

  // Offers a token from just after a rising edge and returns just after the edge that took it.
  task automatic send(input logic [1:0] k, input logic [7:0] c, output int waited);
    tok_valid = 1'b1;
    tok_kind  = k;
    tok_char  = c;
    waited    = 0;
    while (mq.size() > 1) begin
      @(posedge clk); #1;
      waited++;
      if (waited > 20) begin
        check("send_timeout", waited, 0);
        break;
      end
    end
    @(posedge clk); #1;
    tok_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    tok_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    cap.delete();
  endtask

  int w;

  initial begin
    reset = 1'b0; tok_valid = 1'b0; tok_kind = KB; tok_char = 8'h00;
    t2_valid = 1'b0; t2_kind = KB; t2_char = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;
    check("rst_ready", tok_ready, 1);
    check("rst_bal",   balanced,  1);

    // Single BEGIN
    cap.delete();
    send(KB, 8'h00, w);
    check("t1_depth", depth, 1);
    check("t1_bal",   balanced, 0);
    idle(8);
`ifdef BLOCK_EMIT_CASE_MIX_EN
    cmp_str("t1", "bEgIn ");
`else
    cmp_str("t1", "begin ");
`endif

    // BEGIN, END back-to-back
    do_reset();
    send(KB, 8'h00, w);
    send(KE, 8'h00, w);
    check("t2_wait",  w, 5);
    check("t2_depth", depth, 0);
    check("t2_bal",   balanced, 1);
    idle(6);
`ifdef BLOCK_EMIT_CASE_MIX_EN
    cmp_str("t2", "bEgIn EnD ");
`else
    cmp_str("t2", "begin end ");
`endif

    // END at depth 0 is sticky
    do_reset();
    send(KE, 8'h00, w);
    check("t3_err",   err, 1);
    check("t3_depth", depth, 0);
    check("t3_bal",   balanced, 0);
    send(KB, 8'h00, w);
    send(KE, 8'h00, w);
    idle(6);
    check("t3_bal_after", balanced, 0);
`ifdef BLOCK_EMIT_CASE_MIX_EN
    cmp_str("t3", "eNd BeGiN eNd ");
`else
    cmp_str("t3", "end begin end ");
`endif

    // DEPTH_W=2 saturation on the second instance
    do_reset();
    t2_kind  = KB;
    t2_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("t4_depth%0d", k), t2_depth, (k < 3) ? k + 1 : 3);
      check($sformatf("t4_err%0d", k),   t2_err,   (k == 3));
      check($sformatf("t4_bal%0d", k),   t2_bal,   0);
      if (k < 3) repeat (5) begin @(posedge clk); #1; end
    end
    t2_valid = 1'b0;
    idle(8);

    // Reset mid-emission
    do_reset();
    send(KB, 8'h00, w);
    idle(2);
`ifdef BLOCK_EMIT_CASE_MIX_EN
    check("t5_third", out_char, 8'h67);
`else
    check("t5_third", out_char, 8'h67);
`endif
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("t5_valid", out_valid, 0);
    check("t5_char",  out_char,  0);
    check("t5_depth", depth, 0);
    check("t5_err",   err, 0);
    check("t5_bal",   balanced, 1);
    check("t5_ready", tok_ready, 1);
    idle(3);

    // Mixed tokens; RAW is verbatim and does not disturb case alternation
    do_reset();
    send(KB, 8'h00, w);
    send(KE, 8'h00, w);
    send(KR, 8'h78, w);
    send(KR, 8'h41, w);
    send(KS, 8'h55, w);
    send(KB, 8'h00, w);
    idle(10);
`ifdef BLOCK_EMIT_CASE_MIX_EN
    cmp_str("t6", "bEgIn EnD xA bEgIn ");
`else
    cmp_str("t6", "begin end xA begin ");
`endif
    check("t6_depth", depth, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
